// File: rtl/guess_game_n.sv
// guess_game_n
// -----------------------------------------------------------------------------
// Parametrised number-guessing game for a board top level.
//
// While the round is idle (S_GEN) the secret free-runs, one count per clock.
// The first rising edge of the enter button freezes the secret and starts a
// one-cycle compare (S_CHECK). The compare latches exactly one of the
// over/under/equal flags and uses up one try. The round then goes to one of
// three states:
//   - S_WIN  on a correct guess; the score increments and saturates.
//   - S_LOSE when the last try was just used without a match.
//   - S_WAIT otherwise, waiting for the next guess.
// restart begins a new round from any state and keeps the secret and score.
//
// Parameters:
//   WIDTH     - bit width of guess and secret
//   MAX_TRIES - guesses allowed per round (1 .. 2^TRIES_W-1)
//   TRIES_W   - width of the tries counter
//   SCORE_W   - width of the saturating score counter
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   reset    in   asynchronous active-low reset
//   enter    in   guess button (level), edge-detected internally
//   restart  in   new-round request (level), sampled every cycle
//   guess    in   player guess [WIDTH]
//   dp_over  out  latched: last checked guess > secret
//   dp_under out  latched: last checked guess < secret
//   dp_equal out  latched: last checked guess == secret
//   actual   out  current secret [WIDTH]
//   dp_tries out  guesses remaining this round [TRIES_W]
//   win      out  high while in S_WIN
//   lose     out  high while in S_LOSE
//   score    out  rounds won since reset [SCORE_W]
// -----------------------------------------------------------------------------
module guess_game_n #(
    parameter int WIDTH     = 8,
    parameter int MAX_TRIES = 7,
    parameter int TRIES_W   = 4,
    parameter int SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enter,
    input  logic               restart,
    input  logic [WIDTH-1:0]   guess,
    output logic               dp_over,
    output logic               dp_under,
    output logic               dp_equal,
    output logic [WIDTH-1:0]   actual,
    output logic [TRIES_W-1:0] dp_tries,
    output logic               win,
    output logic               lose,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [2:0] {
        S_GEN,
        S_CHECK,
        S_WAIT,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    state_t state;
    logic   enter_q;
    logic   enter_pulse;
    logic   is_over;
    logic   is_under;
    logic   is_equal;

    // A held button gives one pulse: high only on the cycle enter rises.
    assign enter_pulse = enter & ~enter_q;

    // Unsigned compares against the current (frozen) secret.
    assign is_over  = (guess > actual);
    assign is_under = (guess < actual);
    assign is_equal = (guess == actual);

    // Control FSM and all registered outputs.
    // Restart has priority over every other transition. It drops any enter
    // pulse seen in the same cycle, but enter_q still tracks the button, so
    // a held button does not fire a second time once restart is released.
    // The lose decision uses the tries value from before the decrement: a
    // miss with one try left ends the round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_GEN;
            enter_q  <= 1'b0;
            actual   <= '0;
            dp_tries <= TRIES_INIT;
            dp_over  <= 1'b0;
            dp_under <= 1'b0;
            dp_equal <= 1'b0;
            win      <= 1'b0;
            lose     <= 1'b0;
            score    <= '0;
        end else begin
            enter_q <= enter;
            if (restart) begin
                state    <= S_GEN;
                dp_tries <= TRIES_INIT;
                dp_over  <= 1'b0;
                dp_under <= 1'b0;
                dp_equal <= 1'b0;
                win      <= 1'b0;
                lose     <= 1'b0;
            end else begin
                case (state)
                    S_GEN: begin
                        actual <= actual + 1'b1;
                        if (enter_pulse) begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        dp_over  <= is_over;
                        dp_under <= is_under;
                        dp_equal <= is_equal;
                        dp_tries <= dp_tries - 1'b1;
                        if (is_equal) begin
                            state <= S_WIN;
                            win   <= 1'b1;
                            if (score != SCORE_MAX) begin
                                score <= score + 1'b1;
                            end
                        end else if (dp_tries == TRIES_LAST) begin
                            state <= S_LOSE;
                            lose  <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (enter_pulse) begin
                            state <= S_CHECK;
                        end
                    end
                    S_WIN, S_LOSE: begin
                        state <= state;
                    end
                    default: begin
                        state <= S_GEN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_game_n.sv
// tb_guess_game_n
// -----------------------------------------------------------------------------
// Directed bench for guess_game_n. It uses two instances:
//   - main: default parameters (WIDTH=8, MAX_TRIES=7, SCORE_W=8)
//   - small: WIDTH=4, SCORE_W=2, for secret wrap-around and score saturation
// Expected results are queued when a step is driven. They are popped and
// compared once the DUT has had time to respond.
// -----------------------------------------------------------------------------
module tb_guess_game_n;

    typedef struct {
        string      tag;
        bit         sel;        // 0 = main instance, 1 = small instance
        logic       over;
        logic       under;
        logic       equal;
        logic [3:0] tries;
        logic       win;
        logic       lose;
        logic [7:0] score;
        bit         chk_actual;
        logic [7:0] actual;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic       m_reset, m_enter, m_restart;
    logic [7:0] m_guess;
    logic       m_over, m_under, m_equal, m_win, m_lose;
    logic [7:0] m_actual, m_score;
    logic [3:0] m_tries;

    // small instance signals
    logic       s_reset, s_enter, s_restart;
    logic [3:0] s_guess;
    logic       s_over, s_under, s_equal, s_win, s_lose;
    logic [3:0] s_actual;
    logic [1:0] s_score;
    logic [3:0] s_tries;

    guess_game_n dut (
        .clk(clk), .reset(m_reset), .enter(m_enter), .restart(m_restart),
        .guess(m_guess), .dp_over(m_over), .dp_under(m_under),
        .dp_equal(m_equal), .actual(m_actual), .dp_tries(m_tries),
        .win(m_win), .lose(m_lose), .score(m_score)
    );

    guess_game_n #(.WIDTH(4), .MAX_TRIES(7), .TRIES_W(4), .SCORE_W(2)) dut_small (
        .clk(clk), .reset(s_reset), .enter(s_enter), .restart(s_restart),
        .guess(s_guess), .dp_over(s_over), .dp_under(s_under),
        .dp_equal(s_equal), .actual(s_actual), .dp_tries(s_tries),
        .win(s_win), .lose(s_lose), .score(s_score)
    );

    function automatic exp_t mk(string tag, bit sel, bit over, bit under, bit equal,
                                int tries, bit win, bit lose, int score,
                                bit chk_actual, int actual);
        exp_t e;
        e.tag        = tag;
        e.sel        = sel;
        e.over       = over;
        e.under      = under;
        e.equal      = equal;
        e.tries      = 4'(tries);
        e.win        = win;
        e.lose       = lose;
        e.score      = 8'(score);
        e.chk_actual = chk_actual;
        e.actual     = 8'(actual);
        return e;
    endfunction

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s.%s: observed=%0d expected=%0d", tag, field, obs, expv);
        end
    endtask

    // Drive one set of inputs on the selected instance.
    task automatic applyStimulus(input bit sel, input logic en, input logic rs,
                                 input logic [7:0] g);
        if (sel) begin
            s_enter   = en;
            s_restart = rs;
            s_guess   = g[3:0];
        end else begin
            m_enter   = en;
            m_restart = rs;
            m_guess   = g;
        end
    endtask

    // Pop the oldest expectation and compare it with the selected instance.
    task automatic checkOutput();
        exp_t e;
        logic       o_over, o_under, o_equal, o_win, o_lose;
        logic [3:0] o_tries;
        logic [7:0] o_score, o_actual;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = sb_q.pop_front();
        if (e.sel) begin
            o_over = s_over; o_under = s_under; o_equal = s_equal;
            o_win = s_win; o_lose = s_lose; o_tries = s_tries;
            o_score = {6'd0, s_score}; o_actual = {4'd0, s_actual};
        end else begin
            o_over = m_over; o_under = m_under; o_equal = m_equal;
            o_win = m_win; o_lose = m_lose; o_tries = m_tries;
            o_score = m_score; o_actual = m_actual;
        end
        cmp(e.tag, "over",  32'(o_over),  32'(e.over));
        cmp(e.tag, "under", 32'(o_under), 32'(e.under));
        cmp(e.tag, "equal", 32'(o_equal), 32'(e.equal));
        cmp(e.tag, "tries", 32'(o_tries), 32'(e.tries));
        cmp(e.tag, "win",   32'(o_win),   32'(e.win));
        cmp(e.tag, "lose",  32'(o_lose),  32'(e.lose));
        cmp(e.tag, "score", 32'(o_score), 32'(e.score));
        if (e.chk_actual) begin
            cmp(e.tag, "actual", 32'(o_actual), 32'(e.actual));
        end
    endtask

    // One guess: enter rises, the DUT reaches S_CHECK, then the result shows.
    task automatic pulse(input bit sel, input logic [7:0] g, input exp_t e);
        applyStimulus(sel, 1'b1, 1'b0, g);
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
        checkOutput();
        applyStimulus(sel, 1'b0, 1'b0, g);
        @(negedge clk);
    endtask

    // One-cycle restart request, checked right after the restart edge.
    task automatic doRestart(input bit sel, input logic [7:0] g, input exp_t e);
        applyStimulus(sel, 1'b0, 1'b1, g);
        sb_q.push_back(e);
        @(negedge clk);
        checkOutput();
        applyStimulus(sel, 1'b0, 1'b0, g);
    endtask

    initial begin
        m_reset = 1'b0;
        s_reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1, 1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        m_reset = 1'b1;
        s_reset = 1'b1;

        // 1: asynchronous reset mid-count, then 42 counts to the secret
        repeat (5) @(negedge clk);
        #2 m_reset = 1'b0;
        #1;
        sb_q.push_back(mk("async_reset", 0, 0, 0, 0, 7, 0, 0, 0, 1, 0));
        checkOutput();
        @(negedge clk);
        m_reset = 1'b1;
        repeat (41) @(negedge clk);

        // 2: correct first guess, then pulses in S_WIN change nothing
        pulse(0, 8'd42, mk("win_first", 0, 0, 0, 1, 6, 1, 0, 1, 1, 42));
        pulse(0, 8'd42, mk("win_hold1", 0, 0, 0, 1, 6, 1, 0, 1, 1, 42));
        pulse(0, 8'd7,  mk("win_hold2", 0, 0, 0, 1, 6, 1, 0, 1, 1, 42));

        // 3: over, under, then equal; 256 counts bring the secret back to 42
        doRestart(0, 8'd0, mk("restart1", 0, 0, 0, 0, 7, 0, 0, 1, 1, 42));
        repeat (255) @(negedge clk);
        pulse(0, 8'd50, mk("over",  0, 1, 0, 0, 6, 0, 0, 1, 1, 42));
        pulse(0, 8'd10, mk("under", 0, 0, 1, 0, 5, 0, 0, 1, 1, 42));
        pulse(0, 8'd42, mk("win2",  0, 0, 0, 1, 4, 1, 0, 2, 1, 42));

        // 4: seven misses exhaust the round; an eighth pulse is ignored
        doRestart(0, 8'd0, mk("restart2", 0, 0, 0, 0, 7, 0, 0, 2, 1, 42));
        repeat (255) @(negedge clk);
        for (int t = 6; t >= 1; t--) begin
            pulse(0, 8'd0, mk($sformatf("miss%0d", t), 0, 0, 1, 0, t, 0, 0, 2, 1, 42));
        end
        pulse(0, 8'd0, mk("lose",      0, 0, 1, 0, 0, 0, 1, 2, 1, 42));
        pulse(0, 8'd0, mk("lose_hold", 0, 0, 1, 0, 0, 0, 1, 2, 1, 42));

        // 5: held enter checks once; restart with an enter edge skips the check
        doRestart(0, 8'd0, mk("restart3", 0, 0, 0, 0, 7, 0, 0, 2, 1, 42));
        repeat (255) @(negedge clk);
        pulse(0, 8'd0, mk("miss_a", 0, 0, 1, 0, 6, 0, 0, 2, 1, 42));
        applyStimulus(0, 1'b1, 1'b0, 8'd0);
        sb_q.push_back(mk("held_enter", 0, 0, 1, 0, 5, 0, 0, 2, 1, 42));
        repeat (20) @(negedge clk);
        checkOutput();
        applyStimulus(0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1, 8'd0);
        sb_q.push_back(mk("restart_enter", 0, 0, 0, 0, 7, 0, 0, 2, 1, 42));
        @(negedge clk);
        checkOutput();
        applyStimulus(0, 1'b1, 1'b0, 8'd0);
        sb_q.push_back(mk("no_check", 0, 0, 0, 0, 7, 0, 0, 2, 1, 43));
        @(negedge clk);
        checkOutput();
        applyStimulus(0, 1'b0, 1'b0, 8'd0);

        // 6: small instance - secret wraps 15 -> 0, score saturates at 3
        s_reset = 1'b0;
        @(negedge clk);
        s_reset = 1'b1;
        repeat (15) @(negedge clk);
        sb_q.push_back(mk("wrap_15", 1, 0, 0, 0, 7, 0, 0, 0, 1, 15));
        checkOutput();
        @(negedge clk);
        sb_q.push_back(mk("wrap_0", 1, 0, 0, 0, 7, 0, 0, 0, 1, 0));
        checkOutput();
        for (int k = 1; k <= 4; k++) begin
            pulse(1, 8'(k), mk($sformatf("swin%0d", k), 1, 0, 0, 1, 6, 1, 0,
                               (k > 3) ? 3 : k, 1, k));
            doRestart(1, 8'(k), mk($sformatf("srst%0d", k), 1, 0, 0, 0, 7, 0, 0,
                                   (k > 3) ? 3 : k, 1, k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
